mem_arb_2x: RTL

- Round-robin arbiter that shares the single 32x32 memory (wr_en/rd_en/addr/wr_data/data_out/full/empty) between two requesters.
- Each requester issues one read or write at a time using a req/gnt handshake.
- Read data is routed back to the requester that issued the read, with a valid pulse.
- Sits between the memory interface and the two client agents.

---
 rtl/mem_arb_2x_if.sv | 42 ++++
 rtl/mem_arb_2x.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mem_arb_2x_if.sv
// Bundles the two requester ports and the shared memory port of mem_arb_2x.
// The arbiter uses the slave modport; clients plus memory use the master modport.
interface mem_arb_2x_if #(
  parameter int AW = 5,
  parameter int DW = 32
) ();
  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          gnt0;
  logic          gnt1;
  logic          rvalid0;
  logic          rvalid1;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;
  logic          mem_wr_en;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data;
  logic [DW-1:0] mem_data_out;
  logic          mem_full;
  logic          mem_empty;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  mem_data_out, mem_full, mem_empty,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
    output mem_wr_en, mem_rd_en, mem_addr, mem_wr_data
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output mem_data_out, mem_full, mem_empty,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
    input  mem_wr_en, mem_rd_en, mem_addr, mem_wr_data
  );
endinterface

// File: rtl/mem_arb_2x.sv
// Two-requester round-robin arbiter in front of a single 32x32 memory.
// Optional grant statistics and starvation pulse: define MEM_ARB_STATS_EN.
module mem_arb_2x #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_arb_2x_if.slave    bus
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0]    gcnt0,
  output logic [15:0]    gcnt1,
  output logic           starve
`endif
);

  logic          elig0_s;
  logic          elig1_s;
  logic          gnt0_s;
  logic          gnt1_s;
  logic          last1_r;
  logic          mem_wr_en_r;
  logic          mem_rd_en_r;
  logic [AW-1:0] mem_addr_r;
  logic [DW-1:0] mem_wr_data_r;
  logic          id1_r;
  logic          rd_v2_r;
  logic          id2_r;
  logic          rvalid0_r;
  logic          rvalid1_r;
  logic [DW-1:0] rdata0_r;
  logic [DW-1:0] rdata1_r;

  // A write waits for room and for the previous write to leave the bus.
  always_comb begin
    elig0_s = bus.req0 && (!bus.we0 || (!bus.mem_full && !mem_wr_en_r));
    elig1_s = bus.req1 && (!bus.we1 || (!bus.mem_full && !mem_wr_en_r));
  end

  // Round-robin choice; last1_r names the requester granted most recently.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (elig0_s && elig1_s) begin
      if (last1_r) begin
        gnt0_s = 1'b1;
      end else begin
        gnt1_s = 1'b1;
      end
    end else if (elig0_s) begin
      gnt0_s = 1'b1;
    end else if (elig1_s) begin
      gnt1_s = 1'b1;
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  // Register the granted command onto the memory port and advance the pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last1_r       <= 1'b1;
      mem_wr_en_r   <= 1'b0;
      mem_rd_en_r   <= 1'b0;
      mem_addr_r    <= {AW{1'b0}};
      mem_wr_data_r <= {DW{1'b0}};
      id1_r         <= 1'b0;
    end else begin
      mem_wr_en_r <= (gnt0_s && bus.we0) || (gnt1_s && bus.we1);
      mem_rd_en_r <= (gnt0_s && !bus.we0) || (gnt1_s && !bus.we1);
      if (gnt0_s || gnt1_s) begin
        last1_r    <= gnt1_s;
        id1_r      <= gnt1_s;
        mem_addr_r <= gnt1_s ? bus.addr1 : bus.addr0;
        if (gnt1_s ? bus.we1 : bus.we0) begin
          mem_wr_data_r <= gnt1_s ? bus.wdata1 : bus.wdata0;
        end
      end
    end
  end

  // Carry the read tag alongside the memory latency and steer data back.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_v2_r   <= 1'b0;
      id2_r     <= 1'b0;
      rvalid0_r <= 1'b0;
      rvalid1_r <= 1'b0;
      rdata0_r  <= {DW{1'b0}};
      rdata1_r  <= {DW{1'b0}};
    end else begin
      rd_v2_r   <= mem_rd_en_r;
      id2_r     <= id1_r;
      rvalid0_r <= rd_v2_r && !id2_r;
      rvalid1_r <= rd_v2_r && id2_r;
      if (rd_v2_r && !id2_r) begin
        rdata0_r <= bus.mem_data_out;
      end
      if (rd_v2_r && id2_r) begin
        rdata1_r <= bus.mem_data_out;
      end
    end
  end

  assign bus.gnt0        = gnt0_s;
  assign bus.gnt1        = gnt1_s;
  assign bus.mem_wr_en   = mem_wr_en_r;
  assign bus.mem_rd_en   = mem_rd_en_r;
  assign bus.mem_addr    = mem_addr_r;
  assign bus.mem_wr_data = mem_wr_data_r;
  assign bus.rvalid0     = rvalid0_r;
  assign bus.rvalid1     = rvalid1_r;
  assign bus.rdata0      = rdata0_r;
  assign bus.rdata1      = rdata1_r;

`ifdef MEM_ARB_STATS_EN
  logic [15:0] gcnt0_r;
  logic [15:0] gcnt1_r;
  logic [3:0]  wait0_r;
  logic [3:0]  wait1_r;
  logic        starve_r;

  // Saturating grant counters and per-requester wait counters (saturate at 9).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gcnt0_r  <= 16'd0;
      gcnt1_r  <= 16'd0;
      wait0_r  <= 4'd0;
      wait1_r  <= 4'd0;
      starve_r <= 1'b0;
    end else begin
      if (gnt0_s && (gcnt0_r != 16'hFFFF)) begin
        gcnt0_r <= gcnt0_r + 16'd1;
      end
      if (gnt1_s && (gcnt1_r != 16'hFFFF)) begin
        gcnt1_r <= gcnt1_r + 16'd1;
      end
      if (bus.req0 && !gnt0_s) begin
        wait0_r <= (wait0_r == 4'd9) ? wait0_r : wait0_r + 4'd1;
      end else begin
        wait0_r <= 4'd0;
      end
      if (bus.req1 && !gnt1_s) begin
        wait1_r <= (wait1_r == 4'd9) ? wait1_r : wait1_r + 4'd1;
      end else begin
        wait1_r <= 4'd0;
      end
      // Fires once, on the ninth consecutive waiting cycle.
      starve_r <= (bus.req0 && !gnt0_s && (wait0_r == 4'd8)) ||
                  (bus.req1 && !gnt1_s && (wait1_r == 4'd8));
    end
  end

  assign gcnt0  = gcnt0_r;
  assign gcnt1  = gcnt1_r;
  assign starve = starve_r;
`endif

endmodule
